// File: rtl/picoaes_host.sv
`default_nettype none
// ============================================================================
// Module   : picoaes_host
// Purpose  : Bus master that loads key/plaintext into picoaes, starts it,
//            polls STATUS and reads back the ciphertext.
// Revision : 1.0
// ============================================================================
module picoaes_host #(
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter logic [31:0] CTRL_LOAD = 32'h6,
    parameter logic [31:0] CTRL_GO   = 32'h4,
    parameter int          POLL_MAX  = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] pt,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] ct,
    output logic         valid,
    output logic         wen,
    output logic [23:0]  addr,
    output logic [31:0]  wdata,
    input  logic [31:0]  rdata,
    input  logic         ready
);

    localparam int c_PW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;
    localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(POLL_MAX - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WKEY  = 3'd1;
    localparam logic [2:0] c_ST_WPT   = 3'd2;
    localparam logic [2:0] c_ST_WCTRL = 3'd3;
    localparam logic [2:0] c_ST_POLL  = 3'd4;
    localparam logic [2:0] c_ST_RDCT  = 3'd5;
    localparam logic [2:0] c_ST_FIN   = 3'd6;

    logic [2:0]      r_state;
    logic [1:0]      r_cnt;
    logic [c_PW-1:0] r_poll;
    logic [127:0]    r_key;
    logic [127:0]    r_pt;
    logic [127:0]    r_ct;
    logic            r_err;
    logic            r_valid;
    logic            r_wen;
    logic [23:0]     r_addr;
    logic [31:0]     r_wdata;

    logic [2:0]      w_nstate;
    logic [1:0]      w_ncnt;
    logic            w_xfer;
    logic            w_timeout;
    logic            w_bus_req;
    logic            w_wen;
    logic [7:0]      w_off;
    logic [31:0]     w_wdata;
    logic [127:0]    w_key_src;
    logic [127:0]    w_pt_src;

    assign w_xfer = r_valid & ready;

    always_comb begin
        w_nstate  = r_state;
        w_ncnt    = r_cnt;
        w_timeout = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_nstate = c_ST_WKEY;
                    w_ncnt   = 2'd0;
                end
            end
            c_ST_WKEY, c_ST_WPT, c_ST_WCTRL, c_ST_RDCT: begin
                if (w_xfer) begin
                    w_ncnt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        case (r_state)
                            c_ST_WKEY:  w_nstate = c_ST_WPT;
                            c_ST_WPT:   w_nstate = c_ST_WCTRL;
                            c_ST_WCTRL: w_nstate = c_ST_POLL;
                            default:    w_nstate = c_ST_FIN;
                        endcase
                    end
                end
            end
            c_ST_POLL: begin
                if (w_xfer) begin
                    if (rdata[0]) begin
                        w_nstate = c_ST_RDCT;
                        w_ncnt   = 2'd0;
                    end else if (r_poll == c_POLL_LAST) begin
                        w_nstate  = c_ST_FIN;
                        w_timeout = 1'b1;
                    end
                end
            end
            c_ST_FIN: w_nstate = c_ST_IDLE;
            default:  w_nstate = c_ST_IDLE;
        endcase
    end

    // Bus fields are computed for the upcoming state so they appear registered
    // in the same cycle valid rises; a stall recomputes identical values.
    assign w_key_src = (r_state == c_ST_IDLE) ? key : r_key;
    assign w_pt_src  = (r_state == c_ST_IDLE) ? pt  : r_pt;

    always_comb begin
        w_bus_req = 1'b1;
        w_wen     = r_wen;
        w_off     = 8'h00;
        w_wdata   = r_wdata;
        case (w_nstate)
            c_ST_WKEY: begin
                w_wen   = 1'b1;
                w_off   = 8'h10 - {4'b0000, w_ncnt, 2'b00};
                w_wdata = w_key_src[{w_ncnt, 5'b00000} +: 32];
            end
            c_ST_WPT: begin
                w_wen   = 1'b1;
                w_off   = 8'h20 - {4'b0000, w_ncnt, 2'b00};
                w_wdata = w_pt_src[{w_ncnt, 5'b00000} +: 32];
            end
            c_ST_WCTRL: begin
                w_wen   = 1'b1;
                w_off   = 8'h00;
                w_wdata = w_ncnt[1] ? CTRL_GO : CTRL_LOAD;
            end
            c_ST_POLL: begin
                w_wen = 1'b0;
                w_off = 8'h44;
            end
            c_ST_RDCT: begin
                w_wen = 1'b0;
                w_off = 8'h40 - {4'b0000, w_ncnt, 2'b00};
            end
            default: w_bus_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 2'd0;
            r_poll  <= '0;
            r_key   <= '0;
            r_pt    <= '0;
            r_ct    <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_valid <= w_bus_req;
            if (w_bus_req) begin
                r_wen   <= w_wen;
                r_addr  <= BASE_ADDR + {16'h0000, w_off};
                r_wdata <= w_wdata;
            end
            if (r_state == c_ST_IDLE && start) begin
                r_key  <= key;
                r_pt   <= pt;
                r_err  <= 1'b0;
                r_poll <= '0;
            end
            if (r_state == c_ST_POLL && w_xfer && !rdata[0]) begin
                r_poll <= r_poll + c_PW'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (r_state == c_ST_RDCT && w_xfer) begin
                r_ct[{r_cnt, 5'b00000} +: 32] <= rdata;
            end
        end
    end

    assign busy  = (r_state != c_ST_IDLE) && (r_state != c_ST_FIN);
    assign done  = (r_state == c_ST_FIN);
    assign err   = r_err;
    assign ct    = r_ct;
    assign valid = r_valid;
    assign wen   = r_wen;
    assign addr  = r_addr;
    assign wdata = r_wdata;

endmodule
`default_nettype wire

// File: doc/picoaes_host.md
PICOAES_HOST -- requirements
Module: picoaes_host

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h000000: base of the picoaes register map; all addresses below are offsets from it.
REQ-002 SHALL have parameter CTRL_LOAD, default 32'h6: control word written to load key and plaintext.
REQ-003 SHALL have parameter CTRL_GO, default 32'h4: control word written to start encryption.
REQ-004 SHALL have parameter POLL_MAX, default 1023: maximum STATUS reads before timeout.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to run one encryption.
REQ-008 key  in  128  AES key, sampled on an accepted start.
REQ-009 pt  in  128  plaintext, sampled on an accepted start.
REQ-010 busy  out  1  high from accepted start until done.
REQ-011 done  out  1  one-cycle pulse when the sequence ends.
REQ-012 err  out  1  valid with done; 1 = poll timeout.
REQ-013 ct  out  128  ciphertext, held stable from done until the next accepted start.
REQ-014 valid  out  1  bus request.
REQ-015 wen  out  1  1 = write, 0 = read.
REQ-016 addr  out  24  bus address.
REQ-017 wdata  out  32  write data.
REQ-018 rdata  in  32  read data, valid when ready is high.
REQ-019 ready  in  1  responder completes the transfer.

Function
REQ-020 A transfer SHALL complete at a rising edge where valid and ready are both 1; addr, wen and wdata SHALL stay stable while valid=1 and ready=0.
REQ-021 Transfers SHALL be back-to-back; valid SHALL stay 1 across consecutive transfers within a sequence.
REQ-022 start SHALL be accepted only in IDLE; start while busy SHALL be ignored, with key and pt not resampled.
REQ-023 FSM states SHALL be IDLE, WKEY, WPT, WCTRL, POLL, RDCT, FIN; a 2-bit word counter SHALL index the words within a phase.
REQ-024 WKEY SHALL write offsets 0x10, 0x0C, 0x08, 0x04 with key[31:0], key[63:32], key[95:64], key[127:96], in that order.
REQ-025 WPT SHALL write offsets 0x20, 0x1C, 0x18, 0x14 with pt[31:0], pt[63:32], pt[95:64], pt[127:96], in that order.
REQ-026 WCTRL SHALL write offset 0x00 four times: CTRL_LOAD, CTRL_LOAD, CTRL_GO, CTRL_GO.
REQ-027 POLL SHALL read offset 0x44 repeatedly; a completed read with rdata[0]=1 SHALL move to RDCT, otherwise the poll counter increments.
REQ-028 If the poll counter reaches POLL_MAX without rdata[0]=1, the FSM SHALL go to FIN with err=1 and ct unchanged.
REQ-029 RDCT SHALL read offsets 0x40, 0x3C, 0x38, 0x34 into ct[31:0], ct[63:32], ct[95:64], ct[127:96], capturing rdata on each completing edge.
REQ-030 FIN SHALL drive valid=0, pulse done for one cycle and return to IDLE; busy SHALL fall in the same cycle done rises.
REQ-031 With ready tied to 1 and STATUS=1 on the first poll, done SHALL be high in the cycle after the 17th rising edge following the edge that accepts start.
REQ-032 In IDLE, valid=0; wen, addr and wdata SHALL hold their last values (no requirement on them).
REQ-033 Address arithmetic SHALL be BASE_ADDR + offset, modulo 2^24.

Reset
REQ-034 On reset, outputs SHALL be busy=0, done=0, err=0, ct=0, valid=0, wen=0, addr=0, wdata=0; the FSM SHALL be in IDLE and the counters at 0.
REQ-035 Reset mid-sequence SHALL abort the sequence immediately with no done pulse; the next start SHALL run a full sequence.

Verification
REQ-036 Zero-wait bus model of picoaes: key=fb0b38bcad60b76c73377dfd9ce5692f, pt=fb8587bdac1c369369173bceb2ed4785 -> ct=2287d7fc410a4e2059c15b4a2a2b3375, err=0.
REQ-037 Transfer log check: the 12 writes (order and data per REQ-024 to REQ-026) SHALL precede the first STATUS read, and the CT reads SHALL follow the first STATUS=1.
REQ-038 Responder inserts 0–3 random wait states per transfer -> same ct as REQ-036, and addr/wdata/wen SHALL remain stable during every stall.
REQ-039 STATUS held at 0, POLL_MAX=8 -> exactly 8 STATUS reads, done=1 with err=1, and ct unchanged from its previous value.
REQ-040 start re-pulsed during WPT with a different key -> ignored, and the result SHALL equal REQ-036.
REQ-041 reset asserted during POLL -> valid=0 and busy=0 on the next cycle with no done pulse; a subsequent start SHALL complete correctly.
